// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage front end. Issues one word-aligned read at a time to the
// instruction memory, then hands each returned word and its address to the
// decode stage through a single output slot. A one-entry skid buffer catches
// a word that returns while decode is stalled, so no fetched word is lost.
// A redirect from execute has top priority: it retargets the PC, empties the
// output slot and the buffer, and any word still in flight is thrown away
// when it returns.
//
// Ports
//   clk            : rising-edge clock
//   rst_n          : asynchronous, active-low reset
//   imem_req       : read request, high in WAIT and DRAIN
//   imem_addr      : request address, held stable while imem_req is high
//   imem_ack       : memory response valid (may come in the request cycle)
//   imem_rdata     : returned instruction word, valid with imem_ack
//   redirect_valid : branch/jump redirect
//   redirect_pc    : redirect target (low two bits ignored)
//   stall          : decode cannot accept the word in the output slot
//   instr_valid    : instr/instr_pc hold a valid instruction
//   instr          : fetched instruction word
//   instr_pc       : address of instr
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // one quiet cycle after reset before the first request
    WAIT  = 2'd1,  // request outstanding, word will be used
    HOLD  = 2'd2,  // word parked in the buffer, no request issued
    DRAIN = 2'd3   // request outstanding, word will be discarded
  } state_t;

  // State and datapath registers
  state_t      r_state;
  logic [31:0] r_pc;          // next address to fetch
  logic [31:0] r_req_addr;    // address presented on imem_addr
  logic        r_instr_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_buf_valid;
  logic [31:0] r_buf_data;
  logic [31:0] r_buf_pc;

  // Combinational helpers
  state_t      w_state_next;
  logic        w_slot_free;
  logic        w_take;
  logic        w_load_out;
  logic        w_load_buf;
  logic        w_unload_buf;
  logic [31:0] w_pc_inc;
  logic [31:0] w_redirect_target;
  logic [31:0] w_pc_next;
  logic [31:0] w_req_addr_next;

  // The output slot can take a new word when it is empty or being consumed.
  assign w_slot_free       = !r_instr_valid || !stall;

  // A returned word is kept only in WAIT and only if no redirect overrides it.
  assign w_take            = (r_state == WAIT) && imem_ack && !redirect_valid;
  assign w_load_out        = w_take && w_slot_free;
  assign w_load_buf        = w_take && !w_slot_free;
  assign w_unload_buf      = (r_state == HOLD) && !stall && !redirect_valid;

  // 32-bit add wraps naturally from FFFF_FFFC to 0000_0000.
  assign w_pc_inc          = r_pc + 32'd4;
  assign w_redirect_target = {redirect_pc[31:2], 2'b00};

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    w_pc_next = r_pc;
    if (redirect_valid) begin
      w_pc_next = w_redirect_target;
    end else if (w_take) begin
      w_pc_next = w_pc_inc;
    end
  end

  // The request address follows the PC except while a discarded request is
  // still in flight, where the memory must see the original address.
  always_comb begin
    w_req_addr_next = w_pc_next;
    if (w_state_next == DRAIN) begin
      w_req_addr_next = r_req_addr;
    end
  end

  // -------------------------------------------------------------------------
  // FSM process 1: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        // A late ack from a request abandoned by reset is ignored here.
        w_state_next = WAIT;
      end
      WAIT: begin
        if (redirect_valid) begin
          // Ack in the same cycle retires the stale request; otherwise it
          // must be drained before the redirect target can be requested.
          w_state_next = imem_ack ? WAIT : DRAIN;
        end else if (imem_ack) begin
          w_state_next = w_slot_free ? WAIT : HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid || !stall) begin
          w_state_next = WAIT;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          w_state_next = WAIT;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM process 3: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    imem_req = 1'b0;
    case (r_state)
      WAIT, DRAIN: imem_req = 1'b1;
      default:     imem_req = 1'b0;
    endcase
  end

  assign imem_addr   = r_req_addr;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

  // -------------------------------------------------------------------------
  // PC and request address
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      r_pc       <= w_pc_next;
      r_req_addr <= w_req_addr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Output slot: redirect flushes, then a new memory word, then the buffered
  // word; a consumed slot with nothing to refill it goes empty. While stalled
  // and not redirected, nothing here changes.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
    end else if (redirect_valid) begin
      r_instr_valid <= 1'b0;
    end else if (w_load_out) begin
      r_instr_valid <= 1'b1;
      r_instr       <= imem_rdata;
      r_instr_pc    <= r_req_addr;
    end else if (w_unload_buf) begin
      r_instr_valid <= 1'b1;
      r_instr       <= r_buf_data;
      r_instr_pc    <= r_buf_pc;
    end else if (r_instr_valid && !stall) begin
      r_instr_valid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // One-entry skid buffer, filled only when a word returns into a stalled,
  // occupied slot. Only r_buf_valid needs a reset for correctness.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the buffer payload is a single register, so it is cleared on reset
    // as well to keep simulation free of X; a deep storage array would not be.
    if (!rst_n) begin
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
      r_buf_pc    <= '0;
    end else if (redirect_valid) begin
      r_buf_valid <= 1'b0;
    end else if (w_load_buf) begin
      r_buf_valid <= 1'b1;
      r_buf_data  <= imem_rdata;
      r_buf_pc    <= r_req_addr;
    end else if (w_unload_buf) begin
      r_buf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. Stimulus pushes the expected
// (instr_pc, instr) stream into a scoreboard queue; a monitor pops and
// compares every word decode consumes (instr_valid=1, stall=0). Cycle-exact
// checks on reset values, stall hold, drain and redirect are made inline.
// A second instance with RESET_PC=FFFF_FFF8 covers PC wrap-around.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instruction_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  // second instance (wrap-around)
  logic        rst2_n;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_ack2;
  logic [31:0] imem_rdata2;
  logic        redirect_valid2;
  logic [31:0] redirect_pc2;
  logic        stall2;
  logic        instr_valid2;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;

  // memory model controls
  logic [31:0] ack_delay;
  logic [31:0] mem_wait;
  logic        force_ack;
  logic [31:0] rdata_xor;

  int   n_checks;
  int   n_pass;
  exp_t sb_q[$];

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk            (clk),
    .rst_n          (rst2_n),
    .imem_req       (imem_req2),
    .imem_addr      (imem_addr2),
    .imem_ack       (imem_ack2),
    .imem_rdata     (imem_rdata2),
    .redirect_valid (redirect_valid2),
    .redirect_pc    (redirect_pc2),
    .stall          (stall2),
    .instr_valid    (instr_valid2),
    .instr          (instr2),
    .instr_pc       (instr_pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: acks once a request has been waiting ack_delay cycles (0 = same
  // cycle). The returned word is the address XOR a per-test salt.
  assign imem_ack    = force_ack | (imem_req && (mem_wait >= ack_delay));
  assign imem_rdata  = imem_addr ^ rdata_xor;
  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = imem_addr2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    mem_wait <= 32'd0;
    else if (imem_req && imem_ack) mem_wait <= 32'd0;
    else if (imem_req)             mem_wait <= mem_wait + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compare each consumed word against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && instr_valid && !stall && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("sb_instr_pc", instr_pc, e.pc);
      check("sb_instr", instr, e.word);
    end
  end

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = pc ^ rdata_xor;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_test(input logic [31:0] delay, input logic [31:0] salt);
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    force_ack      = 1'b0;
    ack_delay      = delay;
    rdata_xor      = salt;
    sb_q.delete();
    step();
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", sb_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks        = 0;
    n_pass          = 0;
    rst2_n          = 1'b0;
    redirect_valid2 = 1'b0;
    redirect_pc2    = 32'd0;
    stall2          = 1'b0;

    // ---- Test 1: reset values, zero-wait streaming 0,4,8,... ----
    start_test(32'd0, 32'd0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    for (int i = 0; i < 8; i++) push(32'(i * 4));
    rst_n = 1'b1;
    step(); @(negedge clk);
    check("t1_edge1_valid", {31'd0, instr_valid}, 32'd0);
    check("t1_edge1_req", {31'd0, imem_req}, 32'd1);
    step(); @(negedge clk);
    check("t1_edge2_valid", {31'd0, instr_valid}, 32'd1);
    check("t1_edge2_pc", instr_pc, 32'd0);
    wait_drain(50);

    // ---- Test 2: stall for 3 cycles while 8 is in the slot ----
    start_test(32'd0, 32'hA5A5_0000);
    for (int i = 0; i < 8; i++) push(32'(i * 4));
    rst_n = 1'b1;
    step(); step(); step(); step();
    stall = 1'b1;
    @(negedge clk);
    check("t2_slot_pc8", instr_pc, 32'd8);
    step(); @(negedge clk);
    check("t2_hold_pc", instr_pc, 32'd8);
    check("t2_hold_instr", instr, 32'd8 ^ 32'hA5A5_0000);
    check("t2_hold_req", {31'd0, imem_req}, 32'd0);
    step(); @(negedge clk);
    check("t2_hold2_pc", instr_pc, 32'd8);
    check("t2_hold2_valid", {31'd0, instr_valid}, 32'd1);
    check("t2_hold2_req", {31'd0, imem_req}, 32'd0);
    step();
    stall = 1'b0;
    @(negedge clk);
    check("t2_hold3_pc", instr_pc, 32'd8);
    step(); @(negedge clk);
    check("t2_unbuf_pc", instr_pc, 32'd12);
    wait_drain(50);

    // ---- Test 3: redirect during a slow fetch -> DRAIN, stale word dropped ----
    start_test(32'd3, 32'h0F0F_0000);
    push(32'h100); push(32'h104);
    rst_n = 1'b1;
    step(); step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    check("t3_wait_addr", imem_addr, 32'd0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_drain_req", {31'd0, imem_req}, 32'd1);
    check("t3_drain_addr", imem_addr, 32'd0);
    check("t3_drain_valid", {31'd0, instr_valid}, 32'd0);
    step(); step(); @(negedge clk);
    check("t3_after_drain_addr", imem_addr, 32'h100);
    check("t3_after_drain_valid", {31'd0, instr_valid}, 32'd0);
    wait_drain(60);

    // ---- Test 4: redirect coinciding with ack, target low bits forced 0 ----
    start_test(32'd0, 32'h1357_0000);
    push(32'h0); push(32'h200); push(32'h204);
    rst_n = 1'b1;
    step(); step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    @(negedge clk);
    check("t4_pre_pc", instr_pc, 32'd0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_flush_valid", {31'd0, instr_valid}, 32'd0);
    check("t4_new_addr", imem_addr, 32'h200);
    wait_drain(50);

    // ---- Test 5: reset dropped mid-HOLD, late ack in IDLE ----
    start_test(32'd0, 32'd0);
    rst_n = 1'b1;
    step(); step();
    stall = 1'b1;
    step(); @(negedge clk);
    check("t5_hold_req", {31'd0, imem_req}, 32'd0);
    check("t5_hold_valid", {31'd0, instr_valid}, 32'd1);
    check("t5_hold_addr", imem_addr, 32'd8);
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_valid", {31'd0, instr_valid}, 32'd0);
    check("t5_async_req", {31'd0, imem_req}, 32'd0);
    check("t5_async_addr", imem_addr, 32'd0);
    stall = 1'b0;
    push(32'd0); push(32'd4); push(32'd8);
    step();
    force_ack = 1'b1;
    rst_n     = 1'b1;
    step();
    force_ack = 1'b0;
    @(negedge clk);
    check("t5_edge1_valid", {31'd0, instr_valid}, 32'd0);
    step(); @(negedge clk);
    check("t5_edge2_pc", instr_pc, 32'd0);
    check("t5_edge2_valid", {31'd0, instr_valid}, 32'd1);
    wait_drain(50);

    // ---- Test 6: RESET_PC=FFFF_FFF8 wraps to 0 ----
    check("t6_rst_addr", imem_addr2, 32'hFFFF_FFF8);
    step();
    rst2_n = 1'b1;
    step(); @(negedge clk);
    check("t6_edge1_valid", {31'd0, instr_valid2}, 32'd0);
    step(); @(negedge clk);
    check("t6_pc0", instr_pc2, 32'hFFFF_FFF8);
    check("t6_instr0", instr2, 32'hFFFF_FFF8);
    step(); @(negedge clk);
    check("t6_pc1", instr_pc2, 32'hFFFF_FFFC);
    step(); @(negedge clk);
    check("t6_pc2", instr_pc2, 32'h0000_0000);
    check("t6_valid2", {31'd0, instr_valid2}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
